// File: rtl/bloom_hash_gen.sv
// Flow-key hash generator feeding bloom_filter: builds a direction-agnostic TCP key,
// runs two rolling hashes over four key words and emits a pair of distinct SRAM indices.
module bloom_hash_gen #(
  parameter int unsigned SRAM_ADDR_WIDTH = 19,
  parameter logic [31:0] SEED_0          = 32'h0000_0000,
  parameter logic [31:0] SEED_1          = 32'd5381
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tuple_vld,
  output logic                       tuple_rdy,
  input  logic                       tuple_is_ack,
  input  logic [31:0]                src_ip,
  input  logic [31:0]                dst_ip,
  input  logic [15:0]                src_port,
  input  logic [15:0]                dst_port,
  input  logic [31:0]                seq_num,
  input  logic [31:0]                ack_num,
  input  logic [15:0]                payload_len,
  output logic                       is_ack,
  output logic [SRAM_ADDR_WIDTH-1:0] index_0,
  output logic [SRAM_ADDR_WIDTH-1:0] index_1,
  input  logic                       in_rdy,
  output logic                       in_wr,
  output logic [31:0]                pkts_hashed
);

  localparam int unsigned AW    = SRAM_ADDR_WIDTH;
  localparam int unsigned SHIFT = 32 - AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HASH = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_w [4];
  logic [1:0]      r_cnt;
  logic [31:0]     r_h0;
  logic [31:0]     r_h1;
  logic            r_is_ack;
  logic [AW-1:0]   r_idx0;
  logic [AW-1:0]   r_idx1;
  logic [31:0]     r_pkts;

  logic            w_accept;
  logic [31:0]     w_key [4];
  logic [31:0]     w_word;
  logic [31:0]     w_h0_nxt;
  logic [31:0]     w_h1_nxt;
  logic [31:0]     w_h0_sh;
  logic [31:0]     w_h1_sh;
  logic [AW-1:0]   w_fold0;
  logic [AW-1:0]   w_fold1;
  logic [AW-1:0]   w_idx1_fin;

  // ACK keys swap direction so both halves of a flow land on the same key
  always_comb begin
    if (tuple_is_ack) begin
      w_key[0] = dst_ip;
      w_key[1] = src_ip;
      w_key[2] = {dst_port, src_port};
      w_key[3] = ack_num;
    end else begin
      w_key[0] = src_ip;
      w_key[1] = dst_ip;
      w_key[2] = {src_port, dst_port};
      w_key[3] = seq_num + {16'h0000, payload_len};
    end
  end

  // One hash round per cycle, plus the fold of the would-be final accumulators
  always_comb begin
    w_word     = r_w[r_cnt];
    w_h0_nxt   = {r_h0[26:0], r_h0[31:27]} ^ w_word;
    w_h1_nxt   = (r_h1 << 5) + r_h1 + w_word;
    w_h0_sh    = w_h0_nxt >> SHIFT;
    w_h1_sh    = w_h1_nxt >> SHIFT;
    w_fold0    = w_h0_nxt[AW-1:0] ^ w_h0_sh[AW-1:0];
    w_fold1    = w_h1_nxt[AW-1:0] ^ w_h1_sh[AW-1:0];
    w_idx1_fin = (w_fold1 == w_fold0) ? (w_fold1 ^ AW'(1)) : w_fold1;
  end

  always_comb begin
    w_state_nxt = r_state;
    tuple_rdy   = 1'b0;
    in_wr       = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        tuple_rdy = reset;
        w_accept  = reset & tuple_vld;
        if (w_accept) w_state_nxt = S_HASH;
      end
      S_HASH: begin
        if (r_cnt == 2'd3) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        in_wr = reset & in_rdy;
        if (in_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_h0     <= SEED_0;
      r_h1     <= SEED_1;
      r_is_ack <= 1'b0;
      r_idx0   <= '0;
      r_idx1   <= '0;
      r_pkts   <= 32'd0;
      for (int i = 0; i < 4; i++) r_w[i] <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        for (int i = 0; i < 4; i++) r_w[i] <= w_key[i];
        r_is_ack <= tuple_is_ack;
        r_h0     <= SEED_0;
        r_h1     <= SEED_1;
        r_cnt    <= 2'd0;
      end
      if (r_state == S_HASH) begin
        r_h0  <= w_h0_nxt;
        r_h1  <= w_h1_nxt;
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          r_idx0 <= w_fold0;
          r_idx1 <= w_idx1_fin;
        end
      end
      if (in_wr) r_pkts <= r_pkts + 32'd1;
    end
  end

  assign is_ack      = r_is_ack;
  assign index_0     = r_idx0;
  assign index_1     = r_idx1;
  assign pkts_hashed = r_pkts;

endmodule
